// File: rtl/uart_frame_assembler.sv
// Builds 5-byte frames (control byte + 32-bit word, MSB first) from UART bytes.
// Holds each frame for the sandbox handshake; counts bytes lost to overrun.
module uart_frame_assembler #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 8
) (
  input  logic             masterClock,
  input  logic             reset,
  input  logic             rxByteValid,
  input  logic [7:0]       rxByte,
  input  logic             clearDR,
  output logic             dataReceived,
  output logic [7:0]       control,
  output logic [31:0]      inputData,
  output logic             frameError,
  output logic             overrun,
  output logic [CNT_W-1:0] droppedCount
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    HOLD,
    RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [7:0]       ctrl_sh_q, ctrl_sh_d;
  logic [31:0]      data_sh_q, data_sh_d;
  logic [7:0]       control_q, control_d;
  logic [31:0]      data_q, data_d;
  logic             dr_q, dr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             drop;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    ctrl_sh_d = ctrl_sh_q;
    data_sh_d = data_sh_q;
    control_d = control_q;
    data_d    = data_q;
    dr_d      = dr_q;
    ferr_d    = 1'b0;
    ovr_d     = ovr_q;
    drop_d    = drop_q;
    drop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rxByteValid) begin
          ctrl_sh_d = rxByte;
          tmo_d     = '0;
          idx_d     = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (rxByteValid) begin
          data_sh_d = {data_sh_q[23:0], rxByte};
          tmo_d     = '0;
          idx_d     = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            control_d = ctrl_sh_q;
            data_d    = {data_sh_q[23:0], rxByte};
            dr_d      = 1'b1;
            state_d   = HOLD;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Partial frame is abandoned; published outputs stay put
          ferr_d    = 1'b1;
          tmo_d     = '0;
          idx_d     = '0;
          ctrl_sh_d = '0;
          data_sh_d = '0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      HOLD: begin
        drop = rxByteValid;
        if (clearDR) begin
          dr_d    = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        drop = rxByteValid;
        if (!clearDR) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        dr_d    = 1'b0;
      end
    endcase
    if (drop) begin
      ovr_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge masterClock) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tmo_q     <= '0;
      ctrl_sh_q <= '0;
      data_sh_q <= '0;
      control_q <= '0;
      data_q    <= '0;
      dr_q      <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      ctrl_sh_q <= ctrl_sh_d;
      data_sh_q <= data_sh_d;
      control_q <= control_d;
      data_q    <= data_d;
      dr_q      <= dr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      drop_q    <= drop_d;
    end
  end

  assign dataReceived = dr_q;
  assign control      = control_q;
  assign inputData    = data_q;
  assign frameError   = ferr_q;
  assign overrun      = ovr_q;
  assign droppedCount = drop_q;

endmodule
